instr_fetch: RTL and testbench

Instruction fetch unit and producer side of the 32-bit instruction bus consumed by the control decoder.
- Holds the PC and issues word reads to instruction memory.
- Buffers returned words in a small FIFO and hands them downstream over a valid/ready handshake.
- Resolves jump (opcode 6'h02) locally, stops on halt (opcode 6'h3f), and accepts branch redirects from execute.

---
 rtl/instr_fetch.sv | 188 ++++++++++++++++++
 tb/tb_instr_fetch.sv | 455 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch.sv
// Instruction fetch unit: PC, single-outstanding memory reads, head-registered instruction FIFO.
// Optional FETCH_STATS_EN adds the fetch_count handshake counter port.
module instr_fetch #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic [31:0] instruction,
    output logic [31:0] instr_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        halted
`ifdef FETCH_STATS_EN
    ,
    output logic [31:0] fetch_count
`endif
);

    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
    localparam logic [5:0] OP_JUMP = 6'h02;
    localparam logic [5:0] OP_HALT = 6'h3f;

    typedef enum logic [1:0] {
        FETCH    = 2'd0,
        WAIT_RSP = 2'd1,
        HALT     = 2'd2
    } state_t;

    state_t        state, state_nxt;
    logic [31:0]   pc, pc_nxt;
    logic          squash, squash_nxt;
    logic          halted_nxt;

    logic [31:0]   fifo_data [FIFO_DEPTH];
    logic [31:0]   fifo_pc   [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;

    logic          req_fire;
    logic          rsp_fire;
    logic          push;
    logic          pop;
    logic          still_outstanding;
    logic [5:0]    opcode;
    logic [31:0]   pc_plus4;
    logic [31:0]   jump_pc;
    logic          unused_redirect_low;

    assign unused_redirect_low = ^redirect_pc[1:0];

    // Issue gating: with one request in flight at most, the FIFO can never overflow.
    assign imem_req_valid = rst_n && (state == FETCH) && (count < DEPTH_C);
    assign imem_req_addr  = pc;

    assign req_fire = imem_req_valid && imem_req_ready;
    assign rsp_fire = (state == WAIT_RSP) && imem_rsp_valid;
    assign push     = rsp_fire && !squash && !redirect;
    assign pop      = instr_valid && instr_ready;

    assign opcode   = imem_rsp_data[31:26];
    assign pc_plus4 = pc + 32'd4;
    assign jump_pc  = {pc_plus4[31:28], imem_rsp_data[25:0], 2'b00};

    // A request still owes a response after this edge if it was just accepted,
    // or was already in flight and its data is not arriving now.
    assign still_outstanding = req_fire || ((state == WAIT_RSP) && !imem_rsp_valid);

    always_comb begin
        state_nxt  = state;
        pc_nxt     = pc;
        squash_nxt = squash;
        halted_nxt = halted;
        if (redirect) begin
            pc_nxt     = {redirect_pc[31:2], 2'b00};
            halted_nxt = 1'b0;
            if (still_outstanding) begin
                state_nxt  = WAIT_RSP;
                squash_nxt = 1'b1;
            end else begin
                state_nxt  = FETCH;
                squash_nxt = 1'b0;
            end
        end else begin
            case (state)
                FETCH: begin
                    if (req_fire) begin
                        state_nxt = WAIT_RSP;
                    end
                end
                WAIT_RSP: begin
                    if (imem_rsp_valid) begin
                        if (squash) begin
                            squash_nxt = 1'b0;
                            state_nxt  = FETCH;
                        end else if (opcode == OP_JUMP) begin
                            pc_nxt    = jump_pc;
                            state_nxt = FETCH;
                        end else if (opcode == OP_HALT) begin
                            halted_nxt = 1'b1;
                            state_nxt  = HALT;
                        end else begin
                            pc_nxt    = pc_plus4;
                            state_nxt = FETCH;
                        end
                    end
                end
                HALT: begin
                    state_nxt = HALT;
                end
                default: begin
                    state_nxt = FETCH;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= FETCH;
            pc     <= RESET_PC;
            squash <= 1'b0;
            halted <= 1'b0;
        end else begin
            state  <= state_nxt;
            pc     <= pc_nxt;
            squash <= squash_nxt;
            halted <= halted_nxt;
        end
    end

    // FIFO control; a redirect flushes every buffered entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (redirect) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_data[wr_ptr] <= imem_rsp_data;
            fifo_pc[wr_ptr]   <= pc;
        end
    end

    // Head entry is presented straight from storage and forced to zero while empty.
    assign instr_valid = (count != '0);
    assign instruction = instr_valid ? fifo_data[rd_ptr] : 32'd0;
    assign instr_pc    = instr_valid ? fifo_pc[rd_ptr]   : 32'd0;

`ifdef FETCH_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_count <= 32'd0;
        end else if (pop) begin
            fetch_count <= fetch_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: behavioural memory with programmable latency plus a
// stream scoreboard that walks the program from the PC rules.
module tb_instr_fetch;

    localparam logic [31:0] RPC = 32'h0000_0000;
    localparam int          FD  = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic [31:0] instruction;
    logic [31:0] instr_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        halted;
`ifdef FETCH_STATS_EN
    logic [31:0] fetch_count;
`endif

    instr_fetch #(.RESET_PC(RPC), .FIFO_DEPTH(FD)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .instruction    (instruction),
        .instr_pc       (instr_pc),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .redirect       (redirect),
        .redirect_pc    (redirect_pc),
        .halted         (halted)
`ifdef FETCH_STATS_EN
        ,
        .fetch_count    (fetch_count)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int hs_total = 0;

    logic [31:0] prog [logic [31:0]];

    int  mem_k = 1;
    bit  mem_k_rand = 0;
    bit  rdy_rand = 0;
    bit  pend = 0;
    int  left = 0;
    logic [31:0] pend_addr = 32'd0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (prog.exists(a)) return prog[a];
        return {6'h00, a[27:2]} ^ 32'h0001_2345;
    endfunction

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Memory: one request at a time, response k edges after the accepting edge.
    initial begin : mem_model
        bit acc;
        logic [31:0] acc_addr;
        forever begin
            @(negedge clk);
            acc = rst_n && imem_req_valid && imem_req_ready;
            acc_addr = imem_req_addr;
            @(posedge clk);
            #1;
            imem_rsp_valid = 1'b0;
            if (acc) begin
                pend = 1'b1;
                pend_addr = acc_addr;
                left = (mem_k_rand ? int'($urandom_range(1, 4)) : mem_k) - 1;
            end
            if (pend) begin
                if (left == 0) begin
                    imem_rsp_valid = 1'b1;
                    imem_rsp_data = mem_word(pend_addr);
                    pend = 1'b0;
                end else begin
                    left--;
                end
            end
            imem_req_ready = !pend && (!rdy_rand || ($urandom_range(0, 3) != 0));
        end
    end

    // Scoreboard: every delivered instruction must be the next word of the program walk.
    initial begin : scoreboard
        logic [31:0] m_pc;
        logic [31:0] m_next;
        logic [31:0] exp_w;
        bit m_halt;
        m_pc = RPC;
        m_halt = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                m_pc = RPC;
                m_halt = 0;
            end else begin
                if (instr_valid && instr_ready) begin
                    hs_total++;
                    exp_w = mem_word(m_pc);
                    checks++;
                    if (m_halt) begin
                        errors++;
                        $display("FAIL sb_after_halt got %h@%h required nothing after halt", instruction, instr_pc);
                    end else if (instruction !== exp_w || instr_pc !== m_pc) begin
                        errors++;
                        $display("FAIL sb_stream got %h@%h required %h@%h", instruction, instr_pc, exp_w, m_pc);
                    end
                    if (!m_halt) begin
                        m_next = m_pc + 32'd4;
                        if (exp_w[31:26] == 6'h02) m_pc = {m_next[31:28], exp_w[25:0], 2'b00};
                        else if (exp_w[31:26] == 6'h3f) m_halt = 1;
                        else m_pc = m_next;
                    end
                end
                if (redirect) begin
                    m_pc = {redirect_pc[31:2], 2'b00};
                    m_halt = 0;
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic pulse_redirect(input logic [31:0] a);
        @(posedge clk);
        #1;
        redirect = 1'b1;
        redirect_pc = a;
        @(posedge clk);
        #1;
        redirect = 1'b0;
    endtask

    task automatic wait_accept(output logic [31:0] a, output bit ok, input int budget);
        ok = 0;
        a = 32'hxxxx_xxxx;
        for (int c = 0; c < budget; c++) begin
            @(negedge clk);
            if (rst_n && imem_req_valid && imem_req_ready) begin
                a = imem_req_addr;
                ok = 1;
                return;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL reset_req_valid got %b required 0", imem_req_valid); end
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL reset_instr_valid got %b required 0", instr_valid); end
        checks++; if (instruction !== 32'd0) begin errors++; $display("FAIL reset_instruction got %h required 0", instruction); end
        checks++; if (instr_pc !== 32'd0) begin errors++; $display("FAIL reset_instr_pc got %h required 0", instr_pc); end
        checks++; if (halted !== 1'b0) begin errors++; $display("FAIL reset_halted got %b required 0", halted); end
`ifdef FETCH_STATS_EN
        checks++; if (fetch_count !== 32'd0) begin errors++; $display("FAIL reset_fetch_count got %0d required 0", fetch_count); end
`endif
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_sequential();
        int n = 0;
        logic [31:0] pcs [3];
        int cy [3];
        mem_k = 1;
        for (int c = 0; c < 60 && n < 3; c++) begin
            @(negedge clk);
            if (instr_valid && instr_ready) begin
                pcs[n] = instr_pc;
                cy[n] = cyc;
                n++;
            end
        end
        checks++;
        if (n != 3) begin
            errors++;
            $display("FAIL seq_count got %0d required 3", n);
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (pcs[i] !== 32'(4 * i)) begin errors++; $display("FAIL seq_pc%0d got %h required %h", i, pcs[i], 32'(4 * i)); end
            end
            for (int i = 1; i < 3; i++) begin
                checks++;
                if (cy[i] - cy[i-1] != 2) begin errors++; $display("FAIL seq_rate%0d got %0d cycles required 2", i, cy[i] - cy[i-1]); end
            end
        end
    endtask

    task automatic test_jump();
        logic [31:0] acc [$];
        bit got = 0;
        bool_loop: for (int c = 0; c < 60; c++) begin
            if (c == 0) begin
                pulse_redirect(32'h0000_0010);
                checks++;
                if (instr_valid !== 1'b0) begin errors++; $display("FAIL jump_flush got %b required 0", instr_valid); end
            end
            @(negedge clk);
            if (imem_req_valid && imem_req_ready) acc.push_back(imem_req_addr);
            if (!got && instr_valid && instr_ready) begin
                got = 1;
                checks++;
                if (instr_pc !== 32'h10 || instruction !== 32'h0800_0040) begin
                    errors++;
                    $display("FAIL jump_deliver got %h@%h required 08000040@00000010", instruction, instr_pc);
                end
            end
            if (got && acc.size() >= 2) break;
        end
        checks++;
        if (acc.size() < 2 || !got) begin
            errors++;
            $display("FAIL jump_timeout got %0d accepts required 2", acc.size());
        end else begin
            checks++;
            if (acc[0] !== 32'h10) begin errors++; $display("FAIL jump_first_addr got %h required 00000010", acc[0]); end
            checks++;
            if (acc[1] !== 32'h100) begin errors++; $display("FAIL jump_target_addr got %h required 00000100", acc[1]); end
        end
    endtask

    task automatic test_halt();
        bit found = 0;
        int reqs = 0;
        logic [31:0] last = 32'd0;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        repeat (5) @(posedge clk);
        prog[32'h8] = 32'hFC00_0000;
        mem_k = 1;
        #1;
        rst_n = 1'b1;
        for (int c = 0; c < 60 && !found; c++) begin
            @(negedge clk);
            if (imem_rsp_valid && imem_rsp_data == 32'hFC00_0000) found = 1;
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL halt_rsp_timeout got none required halt response");
        end else begin
            checks++;
            if (halted !== 1'b0) begin errors++; $display("FAIL halt_early got %b required 0", halted); end
            @(negedge clk);
            checks++;
            if (halted !== 1'b1) begin errors++; $display("FAIL halt_set got %b required 1", halted); end
            for (int c = 0; c < 20; c++) begin
                if (c > 0) @(negedge clk);
                if (imem_req_valid) reqs++;
                if (instr_valid && instr_ready) last = instruction;
            end
            checks++;
            if (reqs != 0) begin errors++; $display("FAIL halt_reqs got %0d required 0", reqs); end
            checks++;
            if (last !== 32'hFC00_0000) begin errors++; $display("FAIL halt_last got %h required fc000000", last); end
            checks++;
            if (instr_valid !== 1'b0 || halted !== 1'b1) begin
                errors++;
                $display("FAIL halt_drained got valid=%b halted=%b required 0/1", instr_valid, halted);
            end
        end
        prog.delete(32'h8);
    endtask

    task automatic test_redirect();
        logic [31:0] a;
        bit ok;
        checks++;
        if (halted !== 1'b1) begin errors++; $display("FAIL redir_pre_halted got %b required 1", halted); end
        mem_k = 3;
        pulse_redirect(32'h0000_0300);
        checks++;
        if (halted !== 1'b0) begin errors++; $display("FAIL redir_halt_clear got %b required 0", halted); end
        wait_accept(a, ok, 40);
        checks++;
        if (!ok || a !== 32'h300) begin errors++; $display("FAIL redir_first_addr got %h required 00000300", a); end
        pulse_redirect(32'h0000_0202);
        checks++;
        if (instr_valid !== 1'b0) begin errors++; $display("FAIL redir_flush got %b required 0", instr_valid); end
        wait_accept(a, ok, 40);
        checks++;
        if (!ok || a !== 32'h200) begin errors++; $display("FAIL redir_new_addr got %h required 00000200", a); end
        checks++;
        if (instr_valid !== 1'b0) begin errors++; $display("FAIL redir_stale_dropped got %b required 0", instr_valid); end
    endtask

    task automatic test_backpressure();
        int acc = 0;
        int hs = 0;
        logic [31:0] first = 32'hxxxx_xxxx;
        mem_k = 1;
        @(posedge clk);
        #1;
        instr_ready = 1'b0;
        pulse_redirect(32'h0000_0400);
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (imem_req_valid && imem_req_ready) acc++;
        end
        checks++;
        if (acc != FD) begin errors++; $display("FAIL bp_accepts got %0d required %0d", acc, FD); end
        checks++;
        if (instr_valid !== 1'b1 || imem_req_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_full got valid=%b req=%b required 1/0", instr_valid, imem_req_valid);
        end
        @(posedge clk);
        #1;
        instr_ready = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (instr_valid && instr_ready) begin
                if (hs == 0) first = instr_pc;
                hs++;
            end
        end
        checks++;
        if (hs < FD || first !== 32'h400) begin errors++; $display("FAIL bp_release got %0d from %h required >=%0d from 00000400", hs, first, FD); end
    endtask

    task automatic test_wrap();
        logic [31:0] a;
        bit ok;
        mem_k = 1;
        pulse_redirect(32'hFFFF_FFFF);
        wait_accept(a, ok, 40);
        checks++;
        if (!ok || a !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_first got %h required fffffffc", a); end
        wait_accept(a, ok, 40);
        checks++;
        if (!ok || a !== 32'h0) begin errors++; $display("FAIL wrap_next got %h required 00000000", a); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] a;
        bit ok;
        int n = 0;
        mem_k = 3;
        pulse_redirect(32'h0000_0500);
        wait_accept(a, ok, 40);
        checks++;
        if (!ok || a !== 32'h500) begin errors++; $display("FAIL rmid_pre_addr got %h required 00000500", a); end
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        checks++;
        if (imem_req_valid !== 1'b0 || instr_valid !== 1'b0 || instruction !== 32'd0 || instr_pc !== 32'd0 || halted !== 1'b0) begin
            errors++;
            $display("FAIL rmid_zero got req=%b vld=%b ins=%h pc=%h halt=%b required all 0",
                     imem_req_valid, instr_valid, instruction, instr_pc, halted);
        end
`ifdef FETCH_STATS_EN
        checks++;
        if (fetch_count !== 32'd0) begin errors++; $display("FAIL rmid_count_clear got %0d required 0", fetch_count); end
`endif
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        wait_accept(a, ok, 40);
        checks++;
        if (!ok || a !== RPC) begin errors++; $display("FAIL rmid_refetch got %h required %h", a, RPC); end
        for (int c = 0; c < 100 && n < 5; c++) begin
            if (c > 0 || !(instr_valid && instr_ready)) @(negedge clk);
            if (instr_valid && instr_ready) n++;
        end
        @(negedge clk);
        checks++;
        if (n != 5) begin errors++; $display("FAIL rmid_handshakes got %0d required 5", n); end
`ifdef FETCH_STATS_EN
        checks++;
        if (fetch_count !== 32'd5) begin errors++; $display("FAIL rmid_fetch_count got %0d required 5", fetch_count); end
`endif
    endtask

    task automatic test_random();
        int start = hs_total;
        mem_k_rand = 1;
        rdy_rand = 1;
        pulse_redirect(32'h0000_1000);
        for (int c = 0; c < 2000; c++) begin
            @(posedge clk);
            #1;
            instr_ready = ($urandom_range(0, 3) != 0);
            redirect = ($urandom_range(0, 39) == 0);
            redirect_pc = 32'h1000 + 32'($urandom_range(0, 63) * 4) + 32'($urandom_range(0, 3));
        end
        @(posedge clk);
        #1;
        redirect = 1'b0;
        instr_ready = 1'b1;
        mem_k_rand = 0;
        rdy_rand = 0;
        repeat (20) @(negedge clk);
        checks++;
        if (hs_total - start < 100) begin errors++; $display("FAIL rand_progress got %0d required >=100", hs_total - start); end
    endtask

    initial begin
        rst_n = 1'b0;
        imem_req_ready = 1'b1;
        imem_rsp_valid = 1'b0;
        imem_rsp_data = 32'd0;
        instr_ready = 1'b1;
        redirect = 1'b0;
        redirect_pc = 32'd0;
        prog[32'h10] = 32'h0800_0040;
        for (int i = 0; i < 64; i++) begin
            if (i % 7 == 3) prog[32'h1000 + 32'(i * 4)] = {6'h02, 26'(32'h400 + 32'((i * 13) % 64))};
        end
        prog[32'h1000 + 32'(61 * 4)] = 32'hFC00_0000;

        test_reset();
        test_sequential();
        test_jump();
        test_halt();
        test_redirect();
        test_backpressure();
        test_wrap();
        test_reset_mid();
        test_random();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
